// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch/decode slice: instruction field layout,
// the NOP encoding and the fetch FSM state encoding.
package instruction_fetch_pkg;

  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int DST_MSB    = 23;
  localparam int DST_LSB    = 16;
  localparam int SRC1_MSB   = 15;
  localparam int SRC1_LSB   = 8;
  localparam int SRC0_MSB   = 7;
  localparam int SRC0_LSB   = 0;

  // NOP is deliberately non-zero so a flushed slot is distinguishable
  // from a fetched all-zero word.
  localparam logic [3:0]  OP_NOP   = 4'hF;
  localparam logic [27:0] NOP_WORD = {OP_NOP, 24'd0};

  localparam int PERF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // Extract the opcode field of an instruction word.
  function automatic logic [3:0] insn_opcode(input logic [27:0] insn);
    return insn[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_perf_counter.sv
// Saturating event counter used for fetch/bubble statistics.
module fetch_perf_counter #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         iInc,
  output logic [W-1:0] oCount
);

  logic [W-1:0] count_q, count_d;

  // Next count: increment on event, stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (iInc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oCount = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, combinational ROM address, one
// instruction register toward the decoder, stall and branch-flush handling.
// Optional macro FETCH_PERF_COUNTERS_EN adds saturating fetch/bubble counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | fetch word at PC into the IR, advance PC
// ST_STALL | downstream hold: PC and IR frozen
// ST_FLUSH | branch redirect: PC <= target, IR <= NOP, valid dropped
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSN_W   = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0)
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [INSN_W-1:0] oInstruction,
  output logic [ADDR_W-1:0] oPC,
  output logic              oValid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [PERF_CNT_W-1:0] oFetchCount,
  output logic [PERF_CNT_W-1:0] oBubbleCount
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic              valid_q, valid_d;

  // Select this cycle's action (branch beats stall) and the next PC/IR.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    insn_d  = insn_q;
    valid_d = valid_q;
    if (iBranchTaken) begin
      state_d = ST_FLUSH;
      pc_d    = iBranchTarget;
      insn_d  = INSN_W'(NOP_WORD);
      valid_d = 1'b0;
    end else if (iStall) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
      pc_d    = pc_q + ADDR_W'(1);
      opc_d   = pc_q;
      insn_d  = iInstruction;
      valid_d = 1'b1;
    end
  end

  // Fetch state and output registers; reset discards any pending action.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      opc_q   <= '0;
      insn_q  <= INSN_W'(NOP_WORD);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      insn_q  <= insn_d;
      valid_q <= valid_d;
    end
  end

  assign oAddress     = pc_q;
  assign oInstruction = insn_q;
  assign oPC          = opc_q;
  assign oValid       = valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic run_evt;
  logic bubble_evt;

  // Counters follow the action being taken this cycle.
  assign run_evt    = (state_d == ST_RUN);
  assign bubble_evt = (state_d == ST_STALL) || (state_d == ST_FLUSH);

  fetch_perf_counter #(.W(PERF_CNT_W)) u_fetch_cnt (
    .Clock  (Clock),
    .Reset  (Reset),
    .iInc   (run_evt),
    .oCount (oFetchCount)
  );

  fetch_perf_counter #(.W(PERF_CNT_W)) u_bubble_cnt (
    .Clock  (Clock),
    .Reset  (Reset),
    .iInc   (bubble_evt),
    .oCount (oBubbleCount)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [27:0] oInstruction;
  logic [15:0] oPC;
  logic        oValid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] oFetchCount;
  logic [15:0] oBubbleCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  // ROM model: word n holds value n.
  assign iInstruction = 28'(oAddress);

  instruction_fetch dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oInstruction  (oInstruction),
    .oPC           (oPC),
    .oValid        (oValid)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .oFetchCount   (oFetchCount),
    .oBubbleCount  (oBubbleCount)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] e_addr;
    logic [15:0] e_pc;
    logic [27:0] e_insn;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  localparam logic [27:0] NOP = NOP_WORD;

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic [15:0] tgt, input logic [15:0] e_addr,
                              input logic [15:0] e_pc, input logic [27:0] e_insn,
                              input logic e_valid);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt;
    v.e_addr = e_addr; v.e_pc = e_pc; v.e_insn = e_insn; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic stall, input logic br,
                       input logic [15:0] tgt);
    Reset = rst; iStall = stall; iBranchTaken = br; iBranchTarget = tgt;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;

    //            rst stall br tgt        addr     pc       insn         valid
    vecs.push_back(mk(1, 0, 0, 16'd0,     16'd0,   16'd0,   NOP,         0)); // reset x3
    vecs.push_back(mk(1, 0, 0, 16'd0,     16'd0,   16'd0,   NOP,         0));
    vecs.push_back(mk(1, 0, 0, 16'd0,     16'd0,   16'd0,   NOP,         0));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd1,   16'd0,   28'd0,       1)); // free run
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd2,   16'd1,   28'd1,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd3,   16'd2,   28'd2,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd4,   16'd3,   28'd3,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd5,   16'd4,   28'd4,       1));
    vecs.push_back(mk(0, 1, 0, 16'd0,     16'd5,   16'd4,   28'd4,       1)); // stall x3 at PC=5
    vecs.push_back(mk(0, 1, 0, 16'd0,     16'd5,   16'd4,   28'd4,       1));
    vecs.push_back(mk(0, 1, 0, 16'd0,     16'd5,   16'd4,   28'd4,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd6,   16'd5,   28'd5,       1)); // resume
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd7,   16'd6,   28'd6,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd8,   16'd7,   28'd7,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd9,   16'd8,   28'd8,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd10,  16'd9,   28'd9,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd11,  16'd10,  28'd10,      1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd12,  16'd11,  28'd11,      1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd13,  16'd12,  28'd12,      1));
    vecs.push_back(mk(0, 0, 1, 16'd2,     16'd2,   16'd12,  NOP,         0)); // branch at PC=13
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd3,   16'd2,   28'd2,       1));
    vecs.push_back(mk(0, 1, 1, 16'd8,     16'd8,   16'd2,   NOP,         0)); // branch beats stall
    vecs.push_back(mk(0, 0, 1, 16'd8,     16'd8,   16'd2,   NOP,         0)); // target == PC
    vecs.push_back(mk(0, 0, 1, 16'hFFFF,  16'hFFFF,16'd2,   NOP,         0)); // back-to-back
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'h0000,16'hFFFF,28'h000FFFF, 1)); // wrap
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd1,   16'd0,   28'd0,       1));
    vecs.push_back(mk(0, 0, 1, 16'd20,    16'd20,  16'd0,   NOP,         0));
    vecs.push_back(mk(1, 0, 1, 16'd30,    16'd0,   16'd0,   NOP,         0)); // reset during flush
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd1,   16'd0,   28'd0,       1));
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd2,   16'd1,   28'd1,       1));
    vecs.push_back(mk(0, 1, 0, 16'd0,     16'd2,   16'd1,   28'd1,       1));
    vecs.push_back(mk(1, 1, 0, 16'd0,     16'd0,   16'd0,   NOP,         0)); // reset during stall
    vecs.push_back(mk(0, 0, 0, 16'd0,     16'd1,   16'd0,   28'd0,       1));

    // Wait past time zero so the first edge samples the initial inputs.
    #2;
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      chk("oAddress",     i, 32'(oAddress),     32'(vecs[i].e_addr));
      chk("oPC",          i, 32'(oPC),          32'(vecs[i].e_pc));
      chk("oInstruction", i, 32'(oInstruction), 32'(vecs[i].e_insn));
      chk("oValid",       i, 32'(oValid),       32'(vecs[i].e_valid));
    end

    // Combinational address path: oAddress follows a redirect one edge later,
    // and the ROM word for that address is what gets latched next.
    cycle(0, 0, 1, 16'h1234);
    chk("redir_addr", 100, 32'(oAddress), 32'h1234);
    cycle(0, 0, 0, 16'd0);
    chk("redir_insn", 101, 32'(oInstruction), 32'h0001234);
    chk("redir_pc",   102, 32'(oPC),          32'h1234);

`ifdef FETCH_PERF_COUNTERS_EN
    cycle(1, 0, 0, 16'd0);
    chk("fetch_cnt_reset",  200, 32'(oFetchCount),  32'd0);
    chk("bubble_cnt_reset", 201, 32'(oBubbleCount), 32'd0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 16'd0);
    for (int i = 0; i < 3; i++)  cycle(0, 1, 0, 16'd0);
    cycle(0, 0, 1, 16'd40);
    chk("fetch_cnt",  202, 32'(oFetchCount),  32'd10);
    chk("bubble_cnt", 203, 32'(oBubbleCount), 32'd4);
    cycle(1, 0, 0, 16'd0);
    for (int i = 0; i < 65540; i++) cycle(0, 0, 0, 16'd0);
    chk("fetch_cnt_sat",    204, 32'(oFetchCount),  32'hFFFF);
    chk("bubble_cnt_quiet", 205, 32'(oBubbleCount), 32'd0);
    cycle(0, 0, 0, 16'd0);
    chk("fetch_cnt_hold",   206, 32'(oFetchCount),  32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, program-counter and ROM address width.
REQ-002 SHALL have parameter INSN_W, default 28, instruction word width ({opcode[27:24], dst[23:16], src1[15:8], src0[7:0]}).
REQ-003 SHALL have parameter RESET_PC, default 16'd0, PC value after reset.
REQ-004 SHALL have port Clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port Reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port oAddress, output, ADDR_W, instruction address driven to the ROM iAddress.
REQ-007 SHALL have port iInstruction, input, INSN_W, combinational ROM data for oAddress.
REQ-008 SHALL have port iStall, input, 1, downstream hold request.
REQ-009 SHALL have port iBranchTaken, input, 1, redirect request from the execute stage.
REQ-010 SHALL have port iBranchTarget, input, ADDR_W, redirect address; zero-extended 8-bit branch fields arrive here.
REQ-011 SHALL have port oInstruction, output, INSN_W, registered instruction for the decoder.
REQ-012 SHALL have port oPC, output, ADDR_W, address of the instruction in oInstruction.
REQ-013 SHALL have port oValid, output, 1, oInstruction holds a real fetched instruction.

Function
REQ-014 SHALL drive oAddress = PC combinationally; no ROM output register inside this block.
REQ-015 SHALL implement FSM states RUN, STALL, FLUSH; state reflects the action taken in the current cycle.
REQ-016 RUN (iBranchTaken=0, iStall=0): oInstruction<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
REQ-017 SHALL give fetch latency of exactly 1 cycle: word at address A appears on oInstruction the cycle after PC==A.
REQ-018 STALL (iStall=1, iBranchTaken=0): PC, oInstruction, oPC, oValid all hold.
REQ-019 FLUSH (iBranchTaken=1): PC<=iBranchTarget, oInstruction<=NOP_WORD, oValid<=0, oPC holds; branch penalty exactly 1 bubble.
REQ-020 SHALL prioritise Reset > iBranchTaken > iStall > normal fetch; a branch during a stall is taken and the stall is ignored that cycle.
REQ-021 SHALL flush even when iBranchTarget equals current PC.
REQ-022 SHALL wrap PC from 16'hFFFF to 16'h0000 modulo 2^ADDR_W, with no flag and no stall.
REQ-023 Back-to-back iBranchTaken cycles: each redirects PC; oValid stays 0 throughout.

Reset
REQ-024 While Reset=1: PC=RESET_PC, oInstruction=NOP_WORD, oPC=0, oValid=0, state=RUN, perf counters=0.
REQ-025 Reset mid-stall or mid-flush SHALL discard the pending stall or redirect; first fetch is from RESET_PC on the cycle after Reset deasserts.

Configuration
REQ-026 Macro FETCH_PERF_COUNTERS_EN defined: add outputs oFetchCount[15:0] (+1 per RUN cycle) and oBubbleCount[15:0] (+1 per STALL or FLUSH cycle), both saturating at 16'hFFFF and cleared by Reset.
REQ-027 Macro FETCH_PERF_COUNTERS_EN undefined: these ports and their logic are absent; all other behaviour identical.

Structure
REQ-028 Opcode field positions, NOP opcode, NOP_WORD ({NOP, 24'd0}) and FSM state encodings SHALL live in the shared definitions package and be used by decoder, ROM and this block.
REQ-029 Saturating counters SHALL be one sub-module, fetch_perf_counter, instantiated twice only under FETCH_PERF_COUNTERS_EN; the PC/IR logic stays in instruction_fetch.

Verification
REQ-030 Reset 3 cycles, then free-run 4 cycles with ROM[n]=n pattern -> oAddress 0,1,2,3; oPC 0,1,2 with oValid=1 starting one cycle after Reset low.
REQ-031 iStall=1 for 3 cycles with PC=5 -> oAddress stays 5, oInstruction/oPC=4 held, oValid=1; resumes with PC 6 after release.
REQ-032 iBranchTaken=1, target 2, at PC=13 -> next cycle oValid=0, oInstruction=NOP_WORD, oAddress=2; following cycle oPC=2, oValid=1.
REQ-033 iBranchTaken=1 and iStall=1 together, target 8 -> branch taken (oAddress=8); preload PC=16'hFFFF, free-run -> oAddress 16'h0000 next.
REQ-034 Reset asserted during a flush cycle -> all outputs at reset values; first post-reset fetch from RESET_PC.
REQ-035 With FETCH_PERF_COUNTERS_EN: 10 RUN, 3 STALL, 1 FLUSH -> oFetchCount=10, oBubbleCount=4; counter preloaded to 16'hFFFF stays 16'hFFFF.
